// File: rtl/gpio_cfg_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package    : rfsoc_config
// Description: Shared constants for the PS GPIO configuration loader: GPIO
//              bit assignments, default register widths and the commit FSM
//              state encoding.
// Revision   : 1.0 - initial release
// ============================================================================
package rfsoc_config;

    // GPIO bit assignments (index into gpio_in)
    localparam int c_BIT_SDATA              = 0;
    localparam int c_BIT_MASK_CLK           = 1;
    localparam int c_BIT_CHANNEL_SEL_CLK    = 2;
    localparam int c_BIT_CYCLE_COUNT_CLK    = 3;
    localparam int c_BIT_MUX_SET_CLK        = 4;
    localparam int c_BIT_PL_RST             = 5;
    localparam int c_BIT_TRIGGER_LINE       = 6;
    localparam int c_BIT_ADC_NUM_AVG_CLK    = 7;
    localparam int c_BIT_ADC_NUM_CYCLE_CLK  = 8;
    localparam int c_BIT_PRE_DELAY_CLK      = 9;
    localparam int c_BIT_POST_DELAY_CLK     = 10;
    localparam int c_BIT_LOCKING_WAVE_CLK   = 11;  // reserved, not used here
    localparam int c_BIT_MASK_ENABLE_CLK    = 12;

    // Default widths
    localparam int c_DEF_NUM_CH      = 16;
    localparam int c_DEF_GPIO_W      = 16;
    localparam int c_DEF_CYCLE_W     = 256;
    localparam int c_DEF_ADC_W       = 32;
    localparam int c_DEF_MASK_W      = 16;
    localparam int c_DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        FIRE   = 2'd2,
        HOLD   = 2'd3
    } commit_state_t;

endpackage
`default_nettype wire

// File: rtl/gpio_cfg_loader_sync_edge.sv
`default_nettype none
// ============================================================================
// Module     : gpio_sync_edge
// Description: WIDTH-bit synchroniser (SYNC_STAGES flops, minimum 2) followed
//              by a registered rising-edge detector.
// Ports      : clk, rst (async, active-high)
//              gpio_in    [WIDTH] raw asynchronous inputs
//              sync_level [WIDTH] last synchroniser stage
//              rise       [WIDTH] one-cycle pulse, registered, per rising edge
// Revision   : 1.0 - initial release
// ============================================================================
module gpio_sync_edge #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] sync_level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_rise;

    // The rise flag is registered so a GPIO edge sampled at edge E is acted
    // on by the consumer at edge E+SYNC_STAGES+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_prev <= '0;
            r_rise <= '0;
        end else begin
            r_sync[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign sync_level = r_sync[SYNC_STAGES-1];
    assign rise       = r_rise;

endmodule
`default_nettype wire

// File: rtl/gpio_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module     : gpio_cfg_loader
// Description: Serial configuration loader from PS GPIO to DAC/ADC fabric.
//              GPIO lines are synchronised and edge-detected; serial data is
//              shifted MSB-first into shadow registers (shared, or broadcast
//              to channels selected by chan_sel) and committed atomically to
//              the active outputs on a trigger, followed by trigger_pulse.
// Ports      : clk, rst (async, active-high), gpio_in[GPIO_W]
//              cycle_count/pre_delay/post_delay[CYCLE_W], adc_num_avg,
//              adc_cycle_count[ADC_W], mask[NUM_CH][MASK_W], mask_en[NUM_CH],
//              mux_sel[NUM_CH], chan_sel[NUM_CH], trigger_pulse, pl_rst_out,
//              busy, cfg_rdata (only with CFG_READBACK_EN)
// Options    : CFG_READBACK_EN - adds cfg_rdata, the MSB of the shadow
//              register shifted most recently.
// Revision   : 1.0 - initial release
// ============================================================================
module gpio_cfg_loader
    import rfsoc_config::*;
#(
    parameter int NUM_CH      = c_DEF_NUM_CH,
    parameter int GPIO_W      = c_DEF_GPIO_W,
    parameter int CYCLE_W     = c_DEF_CYCLE_W,
    parameter int ADC_W       = c_DEF_ADC_W,
    parameter int MASK_W      = c_DEF_MASK_W,
    parameter int SYNC_STAGES = c_DEF_SYNC_STAGES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [GPIO_W-1:0]             gpio_in,
    output logic [CYCLE_W-1:0]            cycle_count,
    output logic [CYCLE_W-1:0]            pre_delay,
    output logic [CYCLE_W-1:0]            post_delay,
    output logic [ADC_W-1:0]              adc_num_avg,
    output logic [ADC_W-1:0]              adc_cycle_count,
    output logic [NUM_CH-1:0][MASK_W-1:0] mask,
    output logic [NUM_CH-1:0]             mask_en,
    output logic [NUM_CH-1:0]             mux_sel,
    output logic [NUM_CH-1:0]             chan_sel,
    output logic                          trigger_pulse,
    output logic                          pl_rst_out,
    output logic                          busy
`ifdef CFG_READBACK_EN
    ,
    output logic                          cfg_rdata
`endif
);

    logic [GPIO_W-1:0] w_level;
    logic [GPIO_W-1:0] w_rise;
    logic              w_sdata;
    logic              w_pl_rst;
    logic              w_unused;

    gpio_sync_edge #(
        .WIDTH       (GPIO_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .gpio_in    (gpio_in),
        .sync_level (w_level),
        .rise       (w_rise)
    );

    assign w_sdata  = w_level[c_BIT_SDATA];
    assign w_pl_rst = w_level[c_BIT_PL_RST];
    assign w_unused = ^{w_level, w_rise};

    // ------------------------------------------------------------------
    // Shadow registers and channel select
    // ------------------------------------------------------------------
    logic [CYCLE_W-1:0]            r_sh_cycle, r_sh_pre, r_sh_post;
    logic [ADC_W-1:0]              r_sh_avg, r_sh_acyc;
    logic [NUM_CH-1:0][MASK_W-1:0] r_sh_mask;
    logic [NUM_CH-1:0]             r_sh_mask_en, r_sh_mux;
    logic [NUM_CH-1:0]             r_chan_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_cycle   <= '0;
            r_sh_pre     <= '0;
            r_sh_post    <= '0;
            r_sh_avg     <= '0;
            r_sh_acyc    <= '0;
            r_sh_mask    <= '0;
            r_sh_mask_en <= '0;
            r_sh_mux     <= '0;
            r_chan_sel   <= '0;
        end else if (w_pl_rst) begin
            r_sh_cycle   <= '0;
            r_sh_pre     <= '0;
            r_sh_post    <= '0;
            r_sh_avg     <= '0;
            r_sh_acyc    <= '0;
            r_sh_mask    <= '0;
            r_sh_mask_en <= '0;
            r_sh_mux     <= '0;
            r_chan_sel   <= '0;
        end else begin
            if (w_rise[c_BIT_CYCLE_COUNT_CLK])   r_sh_cycle <= {r_sh_cycle[CYCLE_W-2:0], w_sdata};
            if (w_rise[c_BIT_PRE_DELAY_CLK])     r_sh_pre   <= {r_sh_pre[CYCLE_W-2:0], w_sdata};
            if (w_rise[c_BIT_POST_DELAY_CLK])    r_sh_post  <= {r_sh_post[CYCLE_W-2:0], w_sdata};
            if (w_rise[c_BIT_ADC_NUM_AVG_CLK])   r_sh_avg   <= {r_sh_avg[ADC_W-2:0], w_sdata};
            if (w_rise[c_BIT_ADC_NUM_CYCLE_CLK]) r_sh_acyc  <= {r_sh_acyc[ADC_W-2:0], w_sdata};
            // Per-channel registers: broadcast to every selected channel,
            // using chan_sel as it stood before this edge.
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (r_chan_sel[ch]) begin
                    if (w_rise[c_BIT_MASK_CLK])
                        r_sh_mask[ch] <= {r_sh_mask[ch][MASK_W-2:0], w_sdata};
                    if (w_rise[c_BIT_MASK_ENABLE_CLK]) r_sh_mask_en[ch] <= w_sdata;
                    if (w_rise[c_BIT_MUX_SET_CLK])     r_sh_mux[ch]     <= w_sdata;
                end
            end
            if (w_rise[c_BIT_CHANNEL_SEL_CLK]) r_chan_sel <= {r_chan_sel[NUM_CH-2:0], w_sdata};
        end
    end

    // ------------------------------------------------------------------
    // Commit FSM
    // ------------------------------------------------------------------
    commit_state_t r_state, w_state_nxt;
    logic          r_pulse, w_pulse_nxt;
    logic          w_commit;
    logic          w_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    // The pulse is registered out of FIRE so it lands one cycle after the
    // active registers change.
    always_comb begin
        w_state_nxt = r_state;
        w_pulse_nxt = 1'b0;
        w_commit    = 1'b0;
        w_busy      = (r_state != IDLE);
        case (r_state)
            IDLE:    if (w_rise[c_BIT_TRIGGER_LINE]) w_state_nxt = COMMIT;
            COMMIT:  begin
                w_commit    = 1'b1;
                w_state_nxt = FIRE;
            end
            FIRE:    begin
                w_pulse_nxt = 1'b1;
                w_state_nxt = HOLD;
            end
            HOLD:    if (!w_level[c_BIT_TRIGGER_LINE]) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_pl_rst) begin
            w_state_nxt = IDLE;
            w_pulse_nxt = 1'b0;
            w_commit    = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Active registers
    // ------------------------------------------------------------------
    logic [CYCLE_W-1:0]            r_cycle, r_pre, r_post;
    logic [ADC_W-1:0]              r_avg, r_acyc;
    logic [NUM_CH-1:0][MASK_W-1:0] r_mask;
    logic [NUM_CH-1:0]             r_mask_en, r_mux;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle   <= '0;
            r_pre     <= '0;
            r_post    <= '0;
            r_avg     <= '0;
            r_acyc    <= '0;
            r_mask    <= '0;
            r_mask_en <= '0;
            r_mux     <= '0;
        end else if (w_pl_rst) begin
            r_cycle   <= '0;
            r_pre     <= '0;
            r_post    <= '0;
            r_avg     <= '0;
            r_acyc    <= '0;
            r_mask    <= '0;
            r_mask_en <= '0;
            r_mux     <= '0;
        end else if (w_commit) begin
            r_cycle   <= r_sh_cycle;
            r_pre     <= r_sh_pre;
            r_post    <= r_sh_post;
            r_avg     <= r_sh_avg;
            r_acyc    <= r_sh_acyc;
            r_mask    <= r_sh_mask;
            r_mask_en <= r_sh_mask_en;
            r_mux     <= r_sh_mux;
        end
    end

    assign cycle_count     = r_cycle;
    assign pre_delay       = r_pre;
    assign post_delay      = r_post;
    assign adc_num_avg     = r_avg;
    assign adc_cycle_count = r_acyc;
    assign mask            = r_mask;
    assign mask_en         = r_mask_en;
    assign mux_sel         = r_mux;
    assign chan_sel        = r_chan_sel;
    assign trigger_pulse   = r_pulse;
    assign pl_rst_out      = w_pl_rst;
    assign busy            = w_busy;

`ifdef CFG_READBACK_EN
    // ------------------------------------------------------------------
    // Readback: remember which register shifted last and return its MSB
    // ------------------------------------------------------------------
    localparam logic [3:0] c_SRC_NONE    = 4'd0;
    localparam logic [3:0] c_SRC_CYCLE   = 4'd1;
    localparam logic [3:0] c_SRC_PRE     = 4'd2;
    localparam logic [3:0] c_SRC_POST    = 4'd3;
    localparam logic [3:0] c_SRC_AVG     = 4'd4;
    localparam logic [3:0] c_SRC_ACYC    = 4'd5;
    localparam logic [3:0] c_SRC_MASK    = 4'd6;
    localparam logic [3:0] c_SRC_MASK_EN = 4'd7;
    localparam logic [3:0] c_SRC_MUX     = 4'd8;
    localparam logic [3:0] c_SRC_CSEL    = 4'd9;

    logic [3:0] r_rb_src, w_rb_src_nxt;
    logic       r_cfg_rdata, w_rb_msb;
    logic       w_first_mask, w_first_en, w_first_mux;

    // When several clocks rise together they all carry the same bit, so
    // any one of them is a valid source; the lowest code wins.
    always_comb begin
        w_rb_src_nxt = r_rb_src;
        if      (w_rise[c_BIT_CYCLE_COUNT_CLK])   w_rb_src_nxt = c_SRC_CYCLE;
        else if (w_rise[c_BIT_PRE_DELAY_CLK])     w_rb_src_nxt = c_SRC_PRE;
        else if (w_rise[c_BIT_POST_DELAY_CLK])    w_rb_src_nxt = c_SRC_POST;
        else if (w_rise[c_BIT_ADC_NUM_AVG_CLK])   w_rb_src_nxt = c_SRC_AVG;
        else if (w_rise[c_BIT_ADC_NUM_CYCLE_CLK]) w_rb_src_nxt = c_SRC_ACYC;
        else if (w_rise[c_BIT_MASK_CLK])          w_rb_src_nxt = c_SRC_MASK;
        else if (w_rise[c_BIT_MASK_ENABLE_CLK])   w_rb_src_nxt = c_SRC_MASK_EN;
        else if (w_rise[c_BIT_MUX_SET_CLK])       w_rb_src_nxt = c_SRC_MUX;
        else if (w_rise[c_BIT_CHANNEL_SEL_CLK])   w_rb_src_nxt = c_SRC_CSEL;
    end

    // Lowest-indexed selected channel: scan downward so the last hit wins.
    always_comb begin
        w_first_mask = 1'b0;
        w_first_en   = 1'b0;
        w_first_mux  = 1'b0;
        for (int ch = NUM_CH - 1; ch >= 0; ch--) begin
            if (r_chan_sel[ch]) begin
                w_first_mask = r_sh_mask[ch][MASK_W-1];
                w_first_en   = r_sh_mask_en[ch];
                w_first_mux  = r_sh_mux[ch];
            end
        end
    end

    always_comb begin
        w_rb_msb = 1'b0;
        case (r_rb_src)
            c_SRC_CYCLE:   w_rb_msb = r_sh_cycle[CYCLE_W-1];
            c_SRC_PRE:     w_rb_msb = r_sh_pre[CYCLE_W-1];
            c_SRC_POST:    w_rb_msb = r_sh_post[CYCLE_W-1];
            c_SRC_AVG:     w_rb_msb = r_sh_avg[ADC_W-1];
            c_SRC_ACYC:    w_rb_msb = r_sh_acyc[ADC_W-1];
            c_SRC_MASK:    w_rb_msb = w_first_mask;
            c_SRC_MASK_EN: w_rb_msb = w_first_en;
            c_SRC_MUX:     w_rb_msb = w_first_mux;
            c_SRC_CSEL:    w_rb_msb = r_chan_sel[NUM_CH-1];
            default:       w_rb_msb = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rb_src    <= c_SRC_NONE;
            r_cfg_rdata <= 1'b0;
        end else begin
            r_rb_src    <= w_rb_src_nxt;
            r_cfg_rdata <= w_rb_msb;
        end
    end

    assign cfg_rdata = r_cfg_rdata;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gpio_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module     : tb_gpio_cfg_loader
// Description: Self-checking bench for gpio_cfg_loader. Register loads come
//              from a vector table; every commit pushes the expected active
//              state to a queue that is popped and compared on trigger_pulse.
//              Hand-written sequences cover commit latency, held trigger,
//              async reset, soft reset and (with CFG_READBACK_EN) readback.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_gpio_cfg_loader;
    import rfsoc_config::*;

    localparam int c_N = 2;  // SYNC_STAGES

    logic                clk = 1'b0;
    logic                rst;
    logic [15:0]         gpio;
    logic [255:0]        cycle_count, pre_delay, post_delay;
    logic [15:0]         adc_num_avg, adc_cycle_count;
    logic [15:0][15:0]   mask;
    logic [15:0]         mask_en, mux_sel, chan_sel;
    logic                trigger_pulse, pl_rst_out, busy;
`ifdef CFG_READBACK_EN
    logic                cfg_rdata;
`endif

    gpio_cfg_loader #(
        .NUM_CH(16), .GPIO_W(16), .CYCLE_W(256), .ADC_W(16), .MASK_W(16), .SYNC_STAGES(c_N)
    ) dut (
        .clk(clk), .rst(rst), .gpio_in(gpio),
        .cycle_count(cycle_count), .pre_delay(pre_delay), .post_delay(post_delay),
        .adc_num_avg(adc_num_avg), .adc_cycle_count(adc_cycle_count),
        .mask(mask), .mask_en(mask_en), .mux_sel(mux_sel), .chan_sel(chan_sel),
        .trigger_pulse(trigger_pulse), .pl_rst_out(pl_rst_out), .busy(busy)
`ifdef CFG_READBACK_EN
        , .cfg_rdata(cfg_rdata)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pulses = 0;

    typedef struct {
        logic [255:0] cyc, pre, post, mask;
        logic [15:0]  avg, acyc, en, mux;
    } snap_t;

    snap_t q[$];
    snap_t m_act;

    // Reference model of the shadow registers
    logic [255:0]      m_cyc, m_pre, m_post;
    logic [15:0]       m_avg, m_acyc, m_en, m_mux, m_csel;
    logic [15:0][15:0] m_mask;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        m_cyc = '0; m_pre = '0; m_post = '0; m_avg = '0; m_acyc = '0;
        m_en = '0; m_mux = '0; m_csel = '0; m_mask = '0;
        m_act = '{default: '0};
    endtask

    task automatic take_snap(output snap_t s);
        s.cyc = m_cyc; s.pre = m_pre; s.post = m_post; s.mask = m_mask;
        s.avg = m_avg; s.acyc = m_acyc; s.en = m_en; s.mux = m_mux;
    endtask

    task automatic model_shift(input logic [15:0] clks, input logic b);
        if (clks[c_BIT_CYCLE_COUNT_CLK])   m_cyc  = {m_cyc[254:0], b};
        if (clks[c_BIT_PRE_DELAY_CLK])     m_pre  = {m_pre[254:0], b};
        if (clks[c_BIT_POST_DELAY_CLK])    m_post = {m_post[254:0], b};
        if (clks[c_BIT_ADC_NUM_AVG_CLK])   m_avg  = {m_avg[14:0], b};
        if (clks[c_BIT_ADC_NUM_CYCLE_CLK]) m_acyc = {m_acyc[14:0], b};
        for (int ch = 0; ch < 16; ch++) begin
            if (m_csel[ch]) begin
                if (clks[c_BIT_MASK_CLK])        m_mask[ch] = {m_mask[ch][14:0], b};
                if (clks[c_BIT_MASK_ENABLE_CLK]) m_en[ch]   = b;
                if (clks[c_BIT_MUX_SET_CLK])     m_mux[ch]  = b;
            end
        end
        if (clks[c_BIT_CHANNEL_SEL_CLK]) m_csel = {m_csel[14:0], b};
    endtask

    // Shift nbits of val MSB-first with generous setup/hold around each rise.
    task automatic shift_bits(input logic [15:0] clks, input logic [255:0] val, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            logic b;
            b = val[i];
            gpio[c_BIT_SDATA] = b;
            repeat (4) @(negedge clk);
            gpio = gpio | clks;
            repeat (4) @(negedge clk);
            gpio = gpio & ~clks;
            repeat (4) @(negedge clk);
            model_shift(clks, b);
        end
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        int k = 0;
        while (busy !== lvl && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(name, busy, lvl);
    endtask

    task automatic wait_pulse(input int start);
        int k = 0;
        while (n_pulses == start && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("pulse_seen", n_pulses - start, 1);
    endtask

    task automatic do_trigger();
        snap_t s;
        int    start;
        take_snap(s);
        q.push_back(s);
        m_act = s;
        start = n_pulses;
        gpio[c_BIT_TRIGGER_LINE] = 1'b1;
        wait_busy(1'b1, "trig_busy_rise");
        wait_pulse(start);
        gpio[c_BIT_TRIGGER_LINE] = 1'b0;
        wait_busy(1'b0, "trig_busy_fall");
    endtask

    // Scoreboard: each trigger_pulse must match the oldest queued commit.
    always @(negedge clk) begin
        if (!rst && trigger_pulse) begin
            snap_t s;
            n_pulses++;
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: got pulse expected none");
            end else begin
                s = q.pop_front();
                check("sb_cycle_count", cycle_count, s.cyc);
                check("sb_pre_delay", pre_delay, s.pre);
                check("sb_post_delay", post_delay, s.post);
                check("sb_adc_num_avg", adc_num_avg, s.avg);
                check("sb_adc_cycle_count", adc_cycle_count, s.acyc);
                check("sb_mask", mask, s.mask);
                check("sb_mask_en", mask_en, s.en);
                check("sb_mux_sel", mux_sel, s.mux);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0]  clks;
        logic [255:0] val;
        int           nbits;
        bit           trig;
        logic [15:0]  exp_csel;
    } vec_t;

    localparam logic [15:0] c_CK_CSEL = 16'd1 << c_BIT_CHANNEL_SEL_CLK;
    localparam logic [15:0] c_CK_MASK = 16'd1 << c_BIT_MASK_CLK;
    localparam logic [15:0] c_CK_PRE  = 16'd1 << c_BIT_PRE_DELAY_CLK;
    localparam logic [15:0] c_CK_POST = 16'd1 << c_BIT_POST_DELAY_CLK;
    localparam logic [15:0] c_CK_AVG  = 16'd1 << c_BIT_ADC_NUM_AVG_CLK;
    localparam logic [15:0] c_CK_ACYC = 16'd1 << c_BIT_ADC_NUM_CYCLE_CLK;
    localparam logic [15:0] c_CK_CYC  = 16'd1 << c_BIT_CYCLE_COUNT_CLK;
    localparam logic [15:0] c_CK_MUX  = 16'd1 << c_BIT_MUX_SET_CLK;
    localparam logic [15:0] c_CK_EN   = 16'd1 << c_BIT_MASK_ENABLE_CLK;

    initial begin
        vec_t         tbl[7];
        snap_t        s;
        logic [255:0] a5;
        int           pc;

        tbl[0] = '{c_CK_CSEL,            256'h0005, 16, 1'b0, 16'h0005};
        tbl[1] = '{c_CK_MASK,            256'h1234, 16, 1'b1, 16'h0005};
        tbl[2] = '{c_CK_PRE,             256'h3C,    8, 1'b0, 16'h0005};
        tbl[3] = '{c_CK_AVG,             256'hBEEF, 16, 1'b0, 16'h0005};
        tbl[4] = '{c_CK_ACYC,            256'h0F0F, 16, 1'b1, 16'h0005};
        tbl[5] = '{c_CK_CSEL,            256'h8000, 16, 1'b0, 16'h8000};
        tbl[6] = '{c_CK_MUX | c_CK_EN,   256'h1,     1, 1'b1, 16'h8000};

        a5 = {32{8'hA5}};
        clear_model();
        rst  = 1'b1;
        gpio = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_cycle_count", cycle_count, 0);
        check("rst_mask", mask, 0);
        check("rst_chan_sel", chan_sel, 0);
        check("rst_trigger_pulse", trigger_pulse, 0);
        check("rst_busy", busy, 0);
        check("rst_pl_rst_out", pl_rst_out, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_busy", busy, 0);

        // cycle_count load and exact commit latency
        shift_bits(c_CK_CYC, a5, 256);
        take_snap(s);
        q.push_back(s);
        m_act = s;
        gpio[c_BIT_TRIGGER_LINE] = 1'b1;
        @(posedge clk);                      // trigger sampled here
        repeat (c_N + 1) @(posedge clk);
        #1;
        check("lat_busy_at_commit", busy, 1);
        check("lat_cycle_before", cycle_count, 0);
        @(posedge clk); #1;
        check("lat_cycle_after", cycle_count, a5);
        check("lat_pulse_early", trigger_pulse, 0);
        @(posedge clk); #1;
        check("lat_pulse_high", trigger_pulse, 1);
        @(posedge clk); #1;
        check("lat_pulse_one_cycle", trigger_pulse, 0);
        @(negedge clk);
        gpio[c_BIT_TRIGGER_LINE] = 1'b0;
        wait_busy(1'b0, "lat_busy_fall");

        // Table-driven register loads
        for (int i = 0; i < 7; i++) begin
            shift_bits(tbl[i].clks, tbl[i].val, tbl[i].nbits);
            check("tbl_chan_sel", chan_sel, tbl[i].exp_csel);
            if (tbl[i].trig) do_trigger();
        end
        check("mask_ch0_ch2", mask, {192'd0, 16'h1234, 16'h0000, 16'h1234});
        check("mux_sel_15", mux_sel, 16'h8000);
        check("mask_en_15", mask_en, 16'h8000);
        check("pre_delay_3c", pre_delay, 256'h3C);
        check("adc_num_avg_beef", adc_num_avg, 16'hBEEF);

        // Asynchronous reset in the middle of a commit
        gpio[c_BIT_TRIGGER_LINE] = 1'b1;
        wait_busy(1'b1, "arst_busy_rise");
        #1 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_pre_delay", pre_delay, 0);
        check("arst_chan_sel", chan_sel, 0);
        check("arst_mask", mask, 0);
        @(negedge clk);
        gpio = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_model();
        repeat (4) @(negedge clk);

        // Held trigger: one pulse only, late shifts stay in the shadow
        take_snap(s);
        q.push_back(s);
        m_act = s;
        pc = n_pulses;
        gpio[c_BIT_TRIGGER_LINE] = 1'b1;
        wait_pulse(pc);
        shift_bits(c_CK_POST, 256'd7, 3);
        repeat (10) @(negedge clk);
        check("held_post_unchanged", post_delay, m_act.post);
        check("held_single_pulse", n_pulses - pc, 1);
        check("held_busy", busy, 1);
        gpio[c_BIT_TRIGGER_LINE] = 1'b0;
        wait_busy(1'b0, "held_busy_fall");
        do_trigger();
        check("held_post_7", post_delay, 256'd7);

        // Soft reset clears everything and blocks triggers
        shift_bits(c_CK_CYC, 256'd99, 256);
        do_trigger();
        check("plrst_cycle_99", cycle_count, 256'd99);
        gpio[c_BIT_PL_RST] = 1'b1;
        @(posedge clk);
        repeat (c_N + 1) @(posedge clk);
        #1;
        check("plrst_out", pl_rst_out, 1);
        check("plrst_cycle_count", cycle_count, 0);
        check("plrst_post_delay", post_delay, 0);
        check("plrst_mask", mask, 0);
        pc = n_pulses;
        @(negedge clk);
        gpio[c_BIT_TRIGGER_LINE] = 1'b1;
        repeat (12) @(negedge clk);
        check("plrst_no_pulse", n_pulses - pc, 0);
        check("plrst_busy", busy, 0);
        gpio[c_BIT_TRIGGER_LINE] = 1'b0;
        gpio[c_BIT_PL_RST] = 1'b0;
        clear_model();
        repeat (6) @(negedge clk);
        check("plrst_out_low", pl_rst_out, 0);
        do_trigger();

`ifdef CFG_READBACK_EN
        shift_bits(c_CK_AVG, 256'h8000, 16);
        check("rb_msb_one", cfg_rdata, 1);
        shift_bits(c_CK_AVG, 256'h0, 1);
        check("rb_msb_zero", cfg_rdata, 0);
`endif

        repeat (5) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpio_cfg_loader.md
# gpio_cfg_loader

Parametrised serial configuration loader between the PS GPIO bus and the DAC/ADC control fabric. It synchronises the GPIO lines into the fabric clock and edge-detects the per-register shift clocks. Serial data is shifted into shadow registers, either shared or per-channel under a one-hot channel select. All shadow state is committed atomically to the active outputs on a trigger, which also produces a one-cycle fabric trigger pulse.

## Interface
Parameters:
- NUM_CH, 16: number of channels (width of the channel select register).
- GPIO_W, 16: GPIO bus width.
- CYCLE_W, 256: width of the cycle count, pre-delay and post-delay registers.
- ADC_W, 32: width of the ADC average-count and ADC cycle-count registers.
- MASK_W, 16: width of the per-channel mask register.
- SYNC_STAGES, 2: synchroniser depth (minimum 2).

Ports:
- clk  in  1  fabric clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- gpio_in  in  GPIO_W  raw PS GPIO bus; bit indices come from the package.
- cycle_count, pre_delay, post_delay  out  CYCLE_W each  active shared registers.
- adc_num_avg, adc_cycle_count  out  ADC_W each  active shared registers.
- mask  out  NUM_CH x MASK_W  active per-channel mask.
- mask_en, mux_sel  out  NUM_CH each  active per-channel enable and mux bits.
- chan_sel  out  NUM_CH  current (unshadowed) channel select.
- trigger_pulse  out  1  one-cycle trigger to the DAC/ADC controllers.
- pl_rst_out  out  1  synchronised soft-reset level.
- busy  out  1  high while the commit FSM is not IDLE.

## Operation
- Every GPIO bit is synchronised through SYNC_STAGES flops, then registered once more for edge detection. A rise is defined as synchronised=1 and previous=0.
- sdata is taken from the same synchronised stage. The PS must hold sdata stable at least SYNC_STAGES+1 cycles before and after a clock rise.
- On a rise of a shared shift clock, the shadow register shifts MSB-first: reg <= {reg[W-2:0], sdata}.
- On a rise of a per-channel clock (mask, mask_enable, mux_set), the shift applies to every channel whose chan_sel bit is 1. The update is a broadcast, and channels whose bit is 0 are untouched.
- On a rise of channel_sel_clk, the NUM_CH-bit chan_sel shifts directly; chan_sel is not shadowed.
- Simultaneous rises on several shift clocks shift the same sdata bit into each affected register.
- Commit FSM:
  - IDLE: on a trigger_line rise with pl_rst low, go to COMMIT.
  - COMMIT: copy every shadow register to its active register; go to FIRE.
  - FIRE: trigger_pulse=1; go to HOLD.
  - HOLD: wait for synchronised trigger_line=0, then go to IDLE.
- A trigger held high never retriggers. Shift rises arriving in COMMIT, FIRE or HOLD still update the shadow registers and never the active ones.
- While synchronised pl_rst=1: all shadow registers, active registers and chan_sel are cleared every cycle, the FSM is forced to IDLE, and triggers are ignored.
- Reset values: all outputs are 0, the FSM is IDLE, and all synchroniser flops are 0.

## Timing
- A GPIO clock rise sampled at edge E updates the shadow register at edge E+SYNC_STAGES+1.
- A trigger rise sampled at edge E moves the FSM to COMMIT at edge E+SYNC_STAGES+1. Active outputs change at the next edge; trigger_pulse is high the cycle after that, for exactly one cycle.
- Trigger-to-pulse latency is therefore SYNC_STAGES+3 cycles. busy rises with COMMIT.
- pl_rst_out is the synchronised pl_rst with SYNC_STAGES cycles of latency. Clearing takes effect the edge after pl_rst_out rises.
- If rst is asserted mid-shift or mid-commit, everything clears asynchronously. Partial shadow contents are lost.

## Configuration
- CFG_READBACK_EN defined: adds output port cfg_rdata (1 bit).
  - cfg_rdata is registered and equals the MSB of the shadow register shifted most recently.
  - For per-channel registers, it is taken from the lowest-indexed selected channel.
  - Its reset value is 0.
  - This lets the PS shift a value out and verify it by looping back through sdata.
- CFG_READBACK_EN undefined: the port and its tracking logic are absent. All other behaviour is identical.

## Structure
- Shared package rfsoc_config holds:
  - the GPIO bit-index constants (sdata, mask_clk, channel_sel_clk, cycle_count_clk, mux_set_clk, pl_rst, trigger_line, adc_num_avg_clk, adc_num_cycle_count_clk, pre_delay_cycle_clk, post_delay_cycle_clk, locking_waveform_clk, mask_enable_clk);
  - the default widths;
  - a new typedef enum commit_state_t {IDLE, COMMIT, FIRE, HOLD}.
- One sub-module, gpio_sync_edge: a GPIO_W-wide synchroniser plus rise detector. It outputs sync_level[GPIO_W] and rise[GPIO_W].
- locking_waveform_clk is reserved and ignored by this block.

## Test plan
- Shift 256 bits of the pattern 0xA5 repeated via cycle_count_clk, then trigger -> cycle_count=0xA5..A5 exactly SYNC_STAGES+2 cycles after the trigger is sampled; trigger_pulse high one cycle later.
- Set chan_sel=0x0005, then shift mask=0x1234 -> after commit, mask[0]=mask[2]=0x1234 and all other channels 0.
- Hold trigger high for 50 cycles while shifting a new post_delay=7 -> exactly one trigger_pulse, post_delay unchanged until a second trigger, then 7.
- Assert pl_rst after loading cycle_count=99 and committing -> all outputs 0 within SYNC_STAGES+1 cycles; a trigger during pl_rst produces no pulse.
- Raise mux_set_clk and mask_enable_clk on the same edge with sdata=1 and chan_sel=0x8000 -> after commit, mux_sel[15]=1 and mask_en[15]=1.
- With CFG_READBACK_EN defined, shift 0x8000 into adc_num_avg (ADC_W=16) -> cfg_rdata=1 after the last shift, and 0 after one further shift of a 0.
